sccb_config_sequencer: RTL and testbench

//  Parametrised successor to the fixed OV7670 setup sequencer. Walks an external
//  16-bit register table ({sub_addr, data}) and drives an SCCB master via start/ready.

---
 rtl/sccb_config_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_sequencer.sv
// ---------------------------------------------------------------------------
// sccb_config_sequencer
//
// Walks an external 16-bit register table ({sub_addr, data}) and feeds each
// write to an SCCB master over a start/ready handshake. Table entries can
// also be in-table delays ({DELAY_TAG, ms}) or an end marker (END_WORD).
// A power-up wait precedes the first fetch. Each wait on sccb_ready is
// bounded by a timeout, and an abort input forces the error state.
//
// Ports
//   clk               system clock
//   reset             asynchronous, active-low reset
//   start             1-cycle pulse, begins a run (ignored while busy)
//   abort             level, forces ERROR from any busy state
//   rom_addr          table read address
//   rom_data          table word, valid one cycle after rom_addr changes
//   sccb_start        1-cycle command pulse to the SCCB master
//   sccb_sub_address  register address of the current write
//   sccb_set_data     register data of the current write
//   sccb_ready        SCCB master idle/ready
//   busy              high while a run is in progress
//   done              run finished normally (held until the next start)
//   error             run ended by timeout or abort (held until next start)
//   write_count       register writes completed in this run (saturating)
//   dbg_state         current FSM state encoding, for observation only
//
// Handshake with the SCCB master: a command is offered only while
// sccb_ready is 1; sccb_start is then pulsed for exactly one cycle with
// sub/data already stable. The master acknowledges by dropping sccb_ready,
// and signals completion by raising it again. Sub/data stay held until the
// next write entry is decoded.
// ---------------------------------------------------------------------------
module sccb_config_sequencer #(
    parameter int unsigned INPUT_CLK_FREQ = 25000000,
    parameter int unsigned ROM_AW         = 8,
    parameter int unsigned POWERUP_MS     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  DELAY_TAG      = 8'hF0,
    parameter logic [15:0] END_WORD       = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic [7:0]        sccb_sub_address,
    output logic [7:0]        sccb_set_data,
    input  logic              sccb_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW:0]   write_count,
    output logic [3:0]        dbg_state
);

    localparam logic [31:0] CLKS_PER_MS = INPUT_CLK_FREQ / 1000;
    localparam logic [31:0] PWR_CYCLES  = POWERUP_MS * (INPUT_CLK_FREQ / 1000);
    localparam logic [31:0] PWR_LAST    = PWR_CYCLES - 32'd1;
    localparam logic [31:0] TMO_LAST    = TIMEOUT_CYCLES - 32'd1;
    localparam logic [ROM_AW:0] WC_MAX  = {1'b1, {ROM_AW{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PWRUP    = 4'd1,
        S_FETCH    = 4'd2,
        S_DECODE   = 4'd3,
        S_WAIT_RDY = 4'd4,
        S_ISSUE    = 4'd5,
        S_WAIT_ACK = 4'd6,
        S_WAIT_CMP = 4'd7,
        S_DELAY    = 4'd8,
        S_NEXT     = 4'd9,
        S_DONE     = 4'd10,
        S_ERROR    = 4'd11
    } state_e;

    state_e            state_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic              sccb_start_q;
    logic [7:0]        sub_q;
    logic [7:0]        data_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [ROM_AW:0]   write_count_q;
    logic [31:0]       cnt_q;   // power-up and in-table delay counter
    logic [31:0]       tmo_q;   // cycles spent in the current ready wait

    logic [31:0]       delay_cycles_d;
    logic [ROM_AW:0]   write_count_d;

    always_comb begin
        delay_cycles_d = 32'(rom_data[7:0]) * CLKS_PER_MS;
        write_count_d  = (write_count_q == WC_MAX) ? write_count_q
                                                   : write_count_q + (ROM_AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rom_addr_q    <= '0;
            sccb_start_q  <= 1'b0;
            sub_q         <= '0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            write_count_q <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
        end else begin
            // sccb_start is only ever set on the transition into ISSUE,
            // so clearing it here every cycle makes it a one-cycle pulse.
            sccb_start_q <= 1'b0;
            if (abort && busy_q) begin
                // abort outranks every other transition; rom_addr is left
                // pointing at the entry being worked on.
                state_q <= S_ERROR;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (start) begin
                            rom_addr_q    <= '0;
                            write_count_q <= '0;
                            done_q        <= 1'b0;
                            error_q       <= 1'b0;
                            busy_q        <= 1'b1;
                            cnt_q         <= '0;
                            tmo_q         <= '0;
                            state_q       <= (PWR_CYCLES == 32'd0) ? S_FETCH : S_PWRUP;
                        end
                    end
                    S_PWRUP: begin
                        if (cnt_q == PWR_LAST) begin
                            state_q <= S_FETCH;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    // rom_addr is held for this cycle so the table read lands
                    // in DECODE.
                    S_FETCH: state_q <= S_DECODE;
                    S_DECODE: begin
                        if (rom_data == END_WORD) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (rom_data[15:8] == DELAY_TAG) begin
                            if (delay_cycles_d == 32'd0) begin
                                state_q <= S_NEXT;
                            end else begin
                                cnt_q   <= delay_cycles_d;
                                state_q <= S_DELAY;
                            end
                        end else begin
                            sub_q   <= rom_data[15:8];
                            data_q  <= rom_data[7:0];
                            tmo_q   <= '0;
                            state_q <= S_WAIT_RDY;
                        end
                    end
                    S_WAIT_RDY: begin
                        if (sccb_ready) begin
                            sccb_start_q <= 1'b1;
                            state_q      <= S_ISSUE;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 32'd1;
                        end
                    end
                    S_ISSUE: begin
                        tmo_q   <= '0;
                        state_q <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        if (!sccb_ready) begin
                            tmo_q   <= '0;
                            state_q <= S_WAIT_CMP;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 32'd1;
                        end
                    end
                    S_WAIT_CMP: begin
                        if (sccb_ready) begin
                            write_count_q <= write_count_d;
                            state_q       <= S_NEXT;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 32'd1;
                        end
                    end
                    S_DELAY: begin
                        if (cnt_q <= 32'd1) begin
                            state_q <= S_NEXT;
                        end else begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                    S_NEXT: begin
                        // Last table slot ends the run without wrapping.
                        if (&rom_addr_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rom_addr_q <= rom_addr_q + ROM_AW'(1);
                            state_q    <= S_FETCH;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr         = rom_addr_q;
    assign sccb_start       = sccb_start_q;
    assign sccb_sub_address = sub_q;
    assign sccb_set_data    = data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign write_count      = write_count_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sccb_config_sequencer
//
// Drives sccb_config_sequencer with a registered table memory and a simple
// SCCB master model. Expected register writes come from a table-walking
// reference model and are checked in order against every sccb_start pulse.
// ---------------------------------------------------------------------------
module tb_sccb_config_sequencer;

    localparam int CLK_FREQ = 10000;
    localparam int CPMS     = CLK_FREQ / 1000;
    localparam int AW       = 3;
    localparam int DEPTH    = 1 << AW;
    localparam int PWR_MS   = 2;
    localparam int TMO      = 64;
    localparam int TW       = DEPTH * 16;

    // ---------------- clock / reset ----------------
    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic start      = 1'b0;
    logic abort      = 1'b0;
    logic sccb_ready = 1'b1;
    logic [15:0] rom_data = 16'h0000;

    logic [AW-1:0] rom_addr;
    logic          sccb_start;
    logic [7:0]    sccb_sub_address;
    logic [7:0]    sccb_set_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   write_count;
    logic [3:0]    dbg_state;

    always #5 clk = ~clk;

    sccb_config_sequencer #(
        .INPUT_CLK_FREQ (CLK_FREQ),
        .ROM_AW         (AW),
        .POWERUP_MS     (PWR_MS),
        .TIMEOUT_CYCLES (TMO),
        .DELAY_TAG      (8'hF0),
        .END_WORD       (16'hFFFF)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .sccb_start       (sccb_start),
        .sccb_sub_address (sccb_sub_address),
        .sccb_set_data    (sccb_set_data),
        .sccb_ready       (sccb_ready),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .write_count      (write_count),
        .dbg_state        (dbg_state)
    );

    // ---------------- table memory (1-cycle read latency) ----------------
    logic [15:0] rom_mem [DEPTH];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // ---------------- SCCB master model ----------------
    int xfer_len    = 4;
    int ignore_addr = -1;
    int m_busy_cnt  = 0;
    always @(negedge clk) begin
        if (m_busy_cnt > 0) begin
            m_busy_cnt--;
            if (m_busy_cnt == 0) sccb_ready = 1'b1;
        end else if (sccb_start && int'(rom_addr) != ignore_addr) begin
            sccb_ready = 1'b0;
            m_busy_cnt = xfer_len;
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q [$];
    int pulse_t [$];
    int start_t  = 0;
    int n_vec    = 0;
    int n_err    = 0;
    logic prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sccb_start) begin
            pulse_t.push_back(int'($time));
            check("start_pulse_width", 32'(prev_start), 32'd0);
            check("start_only_when_busy", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {16'h0, sccb_sub_address, sccb_set_data}, 32'hDEAD);
            end else begin
                check("write_sub_data", {16'h0, sccb_sub_address, sccb_set_data},
                      {16'h0, exp_q.pop_front()});
            end
        end
        prev_start = sccb_start;
    end

    // ---------------- reference model ----------------
    function automatic logic [TW-1:0] mk(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    // Walks the table the way the sequencer should: writes are queued in
    // order, delay entries contribute nothing, FFFF stops, otherwise the run
    // stops on the last slot.
    task automatic model_run(input logic [TW-1:0] tbl, output int wc, output int end_addr);
        logic [15:0] w;
        bit ended;
        ended    = 1'b0;
        wc       = 0;
        end_addr = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            w = tbl[i*16 +: 16];
            if (!ended) begin
                if (w == 16'hFFFF) begin
                    ended    = 1'b1;
                    end_addr = i;
                end else if (w[15:8] != 8'hF0) begin
                    exp_q.push_back(w);
                    wc++;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_table(input logic [TW-1:0] tbl);
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = tbl[i*16 +: 16];
    endtask

    task automatic pulse_start(input logic with_abort);
        @(negedge clk);
        start   = 1'b1;
        abort   = with_abort;
        start_t = int'($time);
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_finished", 32'(done | error), 32'd1);
    endtask

    task automatic run_vec(input logic [TW-1:0] tbl, input int xfer, input int exp_wc,
                           input int exp_addr, input bit use_model);
        int m_wc, m_addr;
        xfer_len = xfer;
        load_table(tbl);
        exp_q.delete();
        model_run(tbl, m_wc, m_addr);
        if (use_model) begin
            exp_wc   = m_wc;
            exp_addr = m_addr;
        end
        pulse_start(1'b0);
        wait_end(3000);
        check("done", 32'(done), 32'd1);
        check("error", 32'(error), 32'd0);
        check("busy", 32'(busy), 32'd0);
        check("write_count", 32'(write_count), 32'(exp_wc));
        check("rom_addr", 32'(rom_addr), 32'(exp_addr));
        check("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [TW-1:0] tbl;
        logic [7:0]    xfer;
        logic [7:0]    exp_wc;
        logic [7:0]    exp_addr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] tbl;
        logic [15:0]   w;
        int n, k, m_wc, m_addr, gap_plain, gap_f000, gap_f005;

        vecs[0] = '{tbl: mk(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
                    xfer: 8'd20, exp_wc: 8'd2, exp_addr: 8'd2};
        vecs[1] = '{tbl: mk(16'h1001, 16'h1102, 16'h1203, 16'h1304, 16'h1405, 16'h1506, 16'h1607, 16'h1708),
                    xfer: 8'd3, exp_wc: 8'd8, exp_addr: 8'd7};
        vecs[2] = '{tbl: mk(16'hF001, 16'h2233, 16'hF000, 16'h4455, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000),
                    xfer: 8'd5, exp_wc: 8'd2, exp_addr: 8'd4};
        vecs[3] = '{tbl: mk(16'hFFFF, 16'h1001, 16'h1102, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
                    xfer: 8'd4, exp_wc: 8'd0, exp_addr: 8'd0};

        // Reset state, held and after release.
        repeat (3) @(negedge clk);
        check("reset_outputs", {5'b0, rom_addr, sccb_start, sccb_sub_address, sccb_set_data,
                                busy, done, error, write_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_outputs", {5'b0, rom_addr, sccb_start, sccb_sub_address, sccb_set_data,
                               busy, done, error, write_count}, 32'd0);

        // start together with abort from IDLE: start wins.
        xfer_len = 20;
        tbl = vecs[0].tbl;
        load_table(tbl);
        exp_q.delete();
        model_run(tbl, m_wc, m_addr);
        pulse_start(1'b1);
        check("start_abort_busy", 32'(busy), 32'd1);
        check("start_abort_error", 32'(error), 32'd0);
        wait_end(3000);
        check("start_abort_done", 32'(done), 32'd1);
        check("start_abort_wc", 32'(write_count), 32'd2);

        // Hand-written vectors.
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i].tbl, int'(vecs[i].xfer), int'(vecs[i].exp_wc), int'(vecs[i].exp_addr), 1'b0);
        end

        // Delay entries: F000 adds no ms delay, F005 adds exactly 5 ms.
        pulse_t.delete();
        run_vec(mk(16'h1280, 16'h1234, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 4, 0, 0, 1'b1);
        gap_plain = (pulse_t.size() >= 2) ? (pulse_t[1] - pulse_t[0]) / 10 : 0;
        n = (pulse_t.size() >= 1) ? (pulse_t[0] - start_t) / 10 : 0;
        check("powerup_min", 32'(n >= PWR_MS * CPMS), 32'd1);
        check("powerup_max", 32'(n < PWR_MS * CPMS + CPMS), 32'd1);
        pulse_t.delete();
        run_vec(mk(16'h1280, 16'hF000, 16'h1234, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0), 4, 0, 0, 1'b1);
        gap_f000 = (pulse_t.size() >= 2) ? (pulse_t[1] - pulse_t[0]) / 10 : 0;
        pulse_t.delete();
        run_vec(mk(16'h1280, 16'hF005, 16'h1234, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0), 4, 0, 0, 1'b1);
        gap_f005 = (pulse_t.size() >= 2) ? (pulse_t[1] - pulse_t[0]) / 10 : 0;
        check("f000_no_delay", 32'(gap_f000 > gap_plain && gap_f000 - gap_plain < CPMS), 32'd1);
        check("f005_delay", 32'(gap_f005 - gap_f000), 32'(5 * CPMS));

        // abort has no effect in DONE.
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_in_done", {29'b0, busy, done, error}, 32'b010);
        abort = 1'b0;

        // Master never acknowledges entry 3: timeout.
        xfer_len    = 4;
        ignore_addr = 3;
        tbl = mk(16'h1001, 16'h1102, 16'h1203, 16'h1304, 16'h1405, 16'hFFFF, 16'h0, 16'h0);
        load_table(tbl);
        exp_q.delete();
        model_run(tbl, m_wc, m_addr);
        pulse_start(1'b0);
        n = 0;
        while (!(sccb_start && rom_addr == 3'd3) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t3_reached_entry3", 32'(sccb_start && rom_addr == 3'd3), 32'd1);
        n = 0;
        while (!error && n < TMO + 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_timeout_latency", 32'(n), 32'(TMO + 1));
        check("t3_flags", {29'b0, busy, done, error}, 32'b001);
        check("t3_rom_addr", 32'(rom_addr), 32'd3);
        check("t3_write_count", 32'(write_count), 32'd3);
        check("t3_writes_left", 32'(exp_q.size()), 32'd1);
        ignore_addr = -1;
        exp_q.delete();

        // abort while waiting for completion, then a rerun.
        xfer_len = 30;
        tbl = mk(16'h1001, 16'h1102, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        load_table(tbl);
        exp_q.delete();
        model_run(tbl, m_wc, m_addr);
        pulse_start(1'b0);
        n = 0;
        while (!sccb_start && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("t5_abort_flags", {29'b0, busy, done, error}, 32'b001);
        check("t5_abort_wc", 32'(write_count), 32'd0);
        abort = 1'b0;
        n = 0;
        while (!sccb_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp_q.delete();
        model_run(tbl, m_wc, m_addr);
        pulse_start(1'b1);
        check("t5_restart_busy", 32'(busy), 32'd1);
        check("t5_restart_error", 32'(error), 32'd0);
        wait_end(3000);
        check("t5_rerun_done", 32'(done), 32'd1);
        check("t5_rerun_wc", 32'(write_count), 32'(m_wc));
        check("t5_writes_left", 32'(exp_q.size()), 32'd0);

        // start while busy is ignored.
        xfer_len = 6;
        tbl = mk(16'h1001, 16'h1102, 16'h1203, 16'h1304, 16'hFFFF, 16'h0, 16'h0, 16'h0);
        load_table(tbl);
        exp_q.delete();
        model_run(tbl, m_wc, m_addr);
        pulse_start(1'b0);
        n = 0;
        while (rom_addr != 3'd2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        pulse_start(1'b0);
        repeat (2) @(negedge clk);
        check("restart_ignored_addr", 32'(rom_addr >= 3'd2), 32'd1);
        check("restart_ignored_busy", 32'(busy), 32'd1);
        wait_end(3000);
        check("restart_ignored_wc", 32'(write_count), 32'd4);
        check("restart_writes_left", 32'(exp_q.size()), 32'd0);

        // Reset asserted during a delay clears outputs immediately.
        xfer_len = 4;
        tbl = mk(16'h1001, 16'hF003, 16'h1102, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0);
        load_table(tbl);
        exp_q.delete();
        model_run(tbl, m_wc, m_addr);
        pulse_start(1'b0);
        repeat (40) @(negedge clk);
        check("t6_pre_busy", 32'(busy), 32'd1);
        check("t6_pre_addr", 32'(rom_addr), 32'd1);
        check("t6_pre_wc", 32'(write_count), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_reset", {5'b0, rom_addr, sccb_start, sccb_sub_address, sccb_set_data,
                                 busy, done, error, write_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("t6_stays_idle", {29'b0, busy, done, error}, 32'd0);

        // Randomised tables against the reference model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                k = int'($urandom_range(0, 9));
                if (k < 6)      w = {8'($urandom_range(0, 8'hEE)), 8'($urandom_range(0, 255))};
                else if (k < 8) w = {8'hF0, 8'($urandom_range(0, 2))};
                else            w = 16'hFFFF;
                tbl[i*16 +: 16] = w;
            end
            run_vec(tbl, int'($urandom_range(2, 12)), 0, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
